pc_stack: RTL and testbench

Program-counter and 8-level return-stack unit for the PIC16F84 core. It sits directly downstream of the phase sequencer and consumes its `en_PC` (phase 6) and `en_STACK` (phase 7) strobes. It also takes the branch opcode class and literal target from the decoder. It produces the 13-bit fetch address for program memory, handling sequential advance, skip, GOTO, CALL and RETURN with PIC circular-stack semantics.

---
 rtl/pc_stack_pkg.sv | 22 ++
 rtl/pc_stack_lifo.sv | 86 ++++++++
 rtl/pc_stack.sv | 97 +++++++++
 tb/tb_pc_stack.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_stack_pkg.sv
// pc_stack_pkg: shared constants for the PIC16F84 program-counter / return-stack unit.
//   - default PC width and stack depth
//   - branch-class opcode encodings driven by the decoder
//   - FSM state type used by pc_stack
package pc_stack_pkg;

    localparam int unsigned PC_W  = 13;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned PTR_W = $clog2(DEPTH);

    localparam logic [2:0] OP_NEXT   = 3'd0;
    localparam logic [2:0] OP_SKIP   = 3'd1;
    localparam logic [2:0] OP_GOTO   = 3'd2;
    localparam logic [2:0] OP_CALL   = 3'd3;
    localparam logic [2:0] OP_RETURN = 3'd4;

    typedef enum logic [0:0] {
        StIdle,
        StWaitStk
    } state_e;

endpackage

// File: rtl/pc_stack_lifo.sv
// pc_stack_lifo: DEPTH x PC_W circular return stack.
// Ports:
//   i_clock, i_reset     clock, synchronous active-high reset (pointer and flags only)
//   i_push, i_pop        push i_wdata at ptr / pop, one per cycle (push wins)
//   i_wdata              return address to push
//   o_top                combinational read of stack[ptr-1]
//   o_depth, o_ovf, o_unf  saturating level and sticky overflow/underflow
// Macro PC_STACK_FLAGS_EN: when undefined, depth/ovf/unf are tied to zero.
module pc_stack_lifo #(
    parameter int unsigned PC_W  = pc_stack_pkg::PC_W,
    parameter int unsigned DEPTH = pc_stack_pkg::DEPTH
) (
    input  logic            i_clock,
    input  logic            i_reset,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [PC_W-1:0] i_wdata,
    output logic [PC_W-1:0] o_top,
    output logic [3:0]      o_depth,
    output logic            o_ovf,
    output logic            o_unf
);
    import pc_stack_pkg::*;

    localparam int unsigned AW = $clog2(DEPTH);

    logic [PC_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]   r_ptr;
    logic [AW-1:0]   w_top_idx;

    // Pointer wraps like silicon: pop on empty reads stale stack[ptr-1].
    assign w_top_idx = r_ptr - AW'(1);
    assign o_top     = r_mem[w_top_idx];

    // Contents are deliberately not reset.
    always_ff @(posedge i_clock) begin
        if (i_push) begin
            r_mem[r_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_ptr <= '0;
        end else if (i_push) begin
            r_ptr <= r_ptr + AW'(1);
        end else if (i_pop) begin
            r_ptr <= r_ptr - AW'(1);
        end
    end

`ifdef PC_STACK_FLAGS_EN
    logic [3:0] r_depth;
    logic       r_ovf;
    logic       r_unf;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (i_push) begin
            if (r_depth == 4'(DEPTH)) begin
                r_ovf <= 1'b1;
            end else begin
                r_depth <= r_depth + 4'd1;
            end
        end else if (i_pop) begin
            if (r_depth == 4'd0) begin
                r_unf <= 1'b1;
            end else begin
                r_depth <= r_depth - 4'd1;
            end
        end
    end

    assign o_depth = r_depth;
    assign o_ovf   = r_ovf;
    assign o_unf   = r_unf;
`else
    assign o_depth = 4'd0;
    assign o_ovf   = 1'b0;
    assign o_unf   = 1'b0;
`endif

endmodule

// File: rtl/pc_stack.sv
// pc_stack: program counter and 8-level return stack for the PIC16F84 core.
// Ports:
//   clock, reset         clock, synchronous active-high reset
//   en_pc                sequencer phase-6 strobe: compute next pc from op
//   en_stack             sequencer phase-7 strobe: commit pending push/pop
//   op, target, pclath_hi  decoder branch class, k[10:0], PCLATH[4:3]
//   pc                   registered fetch address
//   depth, ovf, unf      stack level and sticky flags (zero unless PC_STACK_FLAGS_EN)
// Macro PC_STACK_FLAGS_EN enables the depth/ovf/unf logic in pc_stack_lifo.
module pc_stack #(
    parameter int unsigned PC_W  = pc_stack_pkg::PC_W,
    parameter int unsigned DEPTH = pc_stack_pkg::DEPTH
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            en_pc,
    input  logic            en_stack,
    input  logic [2:0]      op,
    input  logic [10:0]     target,
    input  logic [1:0]      pclath_hi,
    output logic [PC_W-1:0] pc,
    output logic [3:0]      depth,
    output logic            ovf,
    output logic            unf
);
    import pc_stack_pkg::*;

    state_e          r_state, w_state_d;
    logic [2:0]      r_op, w_op_d;
    logic [PC_W-1:0] r_pc, w_pc_d;
    logic [PC_W-1:0] r_ret, w_ret_d;
    logic [PC_W-1:0] w_top, w_jump, w_pc_inc;
    logic            w_push, w_pop;

    assign w_jump   = PC_W'({pclath_hi, target});
    assign w_pc_inc = r_pc + PC_W'(1);

    always_comb begin
        w_state_d = r_state;
        w_op_d    = r_op;
        w_pc_d    = r_pc;
        w_ret_d   = r_ret;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        // en_pc always wins; in StWaitStk it silently drops the pending stack op.
        if (en_pc) begin
            w_op_d    = op;
            w_state_d = StWaitStk;
            case (op)
                OP_SKIP:          w_pc_d = r_pc + PC_W'(2);
                OP_GOTO, OP_CALL: w_pc_d = w_jump;
                OP_RETURN:        w_pc_d = w_top;
                default:          w_pc_d = w_pc_inc;
            endcase
            if (op == OP_CALL) begin
                w_ret_d = w_pc_inc;
            end
        end else if (en_stack && (r_state == StWaitStk)) begin
            // Gate with reset so a mid-instruction reset cannot corrupt the stack.
            w_push    = (r_op == OP_CALL) && !reset;
            w_pop     = (r_op == OP_RETURN) && !reset;
            w_state_d = StIdle;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= StIdle;
            r_op    <= OP_NEXT;
            r_pc    <= '0;
            r_ret   <= '0;
        end else begin
            r_state <= w_state_d;
            r_op    <= w_op_d;
            r_pc    <= w_pc_d;
            r_ret   <= w_ret_d;
        end
    end

    assign pc = r_pc;

    pc_stack_lifo #(
        .PC_W  (PC_W),
        .DEPTH (DEPTH)
    ) u_lifo (
        .i_clock (clock),
        .i_reset (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (r_ret),
        .o_top   (w_top),
        .o_depth (depth),
        .o_ovf   (ovf),
        .o_unf   (unf)
    );

endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: directed scoreboard bench for pc_stack.
// Stimulus pushes hand-computed expectations; a negedge monitor pops and compares.
// With PC_STACK_FLAGS_EN undefined, depth/ovf/unf are expected to read zero.
module tb_pc_stack;

`ifdef PC_STACK_FLAGS_EN
    localparam bit FlagsEn = 1'b1;
`else
    localparam bit FlagsEn = 1'b0;
`endif

    localparam logic [2:0] NXT = 3'd0;
    localparam logic [2:0] SKP = 3'd1;
    localparam logic [2:0] GTO = 3'd2;
    localparam logic [2:0] CLL = 3'd3;
    localparam logic [2:0] RET = 3'd4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        en_pc = 1'b0;
    logic        en_stack = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [10:0] target = 11'd0;
    logic [1:0]  pclath_hi = 2'd0;
    logic [12:0] pc;
    logic [3:0]  depth;
    logic        ovf;
    logic        unf;

    pc_stack dut (
        .clock     (clock),
        .reset     (reset),
        .en_pc     (en_pc),
        .en_stack  (en_stack),
        .op        (op),
        .target    (target),
        .pclath_hi (pclath_hi),
        .pc        (pc),
        .depth     (depth),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clock = ~clock;

    logic [12:0] q_pc[$];
    logic [3:0]  q_dep[$];
    logic        q_ovf[$];
    logic        q_unf[$];
    string       q_name[$];
    int          checks = 0;
    int          failures = 0;
    logic [12:0] last_pc = 13'd0;

    task automatic expect_out(logic [12:0] p, int d, bit o, bit u, string nm);
        q_pc.push_back(p);
        q_dep.push_back(FlagsEn ? 4'(d) : 4'd0);
        q_ovf.push_back(FlagsEn & o);
        q_unf.push_back(FlagsEn & u);
        q_name.push_back(nm);
        last_pc = p;
    endtask

    task automatic drive(bit p, bit s, logic [2:0] o, logic [12:0] a);
        @(negedge clock);
        en_pc     = p;
        en_stack  = s;
        op        = o;
        target    = a[10:0];
        pclath_hi = a[12:11];
        @(posedge clock);
        #1;
        en_pc    = 1'b0;
        en_stack = 1'b0;
    endtask

    task automatic pcop(logic [2:0] o, logic [12:0] a, logic [12:0] epc, int d, bit ov, bit un,
                        string nm);
        drive(1'b1, 1'b0, o, a);
        expect_out(epc, d, ov, un, nm);
    endtask

    task automatic stk(int d, bit ov, bit un, string nm);
        drive(1'b0, 1'b1, NXT, 13'd0);
        expect_out(last_pc, d, ov, un, nm);
    endtask

    task automatic do_reset(string nm);
        @(negedge clock);
        reset    = 1'b1;
        en_pc    = 1'b0;
        en_stack = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        expect_out(13'd0, 0, 1'b0, 1'b0, nm);
    endtask

    task automatic cmp(string nm, string field, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s.%s: got 0x%0h expected 0x%0h", nm, field, got, exp);
        end
    endtask

    // Monitor: outputs are registered, so each expectation is due at the next negedge.
    always @(negedge clock) begin : mon
        logic [12:0] ep;
        logic [3:0]  ed;
        logic        eo, eu;
        string       nm;
        if (q_pc.size() != 0) begin
            ep = q_pc.pop_front();
            ed = q_dep.pop_front();
            eo = q_ovf.pop_front();
            eu = q_unf.pop_front();
            nm = q_name.pop_front();
            cmp(nm, "pc", int'(pc), int'(ep));
            cmp(nm, "depth", int'(depth), int'(ed));
            cmp(nm, "ovf", int'(ovf), int'(eo));
            cmp(nm, "unf", int'(unf), int'(eu));
        end
    end

    initial begin
        do_reset("reset");

        // Sequential advance.
        for (int i = 0; i < 4; i++) begin
            pcop(NXT, 13'd0, 13'(i + 1), 0, 1'b0, 1'b0, "next");
            stk(0, 1'b0, 1'b0, "next_stk");
        end

        // CALL / RETURN round trip.
        pcop(GTO, 13'h0010, 13'h0010, 0, 1'b0, 1'b0, "goto10");
        stk(0, 1'b0, 1'b0, "goto10_stk");
        pcop(CLL, 13'h0923, 13'h0923, 0, 1'b0, 1'b0, "call923");
        stk(1, 1'b0, 1'b0, "call923_push");
        pcop(RET, 13'd0, 13'h0011, 1, 1'b0, 1'b0, "ret11");
        stk(0, 1'b0, 1'b0, "ret11_pop");

        // Modulo-2^13 arithmetic and undefined op codes.
        pcop(GTO, 13'h1FFF, 13'h1FFF, 0, 1'b0, 1'b0, "goto1fff");
        stk(0, 1'b0, 1'b0, "goto1fff_stk");
        pcop(NXT, 13'd0, 13'h0000, 0, 1'b0, 1'b0, "next_wrap");
        pcop(GTO, 13'h1FFF, 13'h1FFF, 0, 1'b0, 1'b0, "goto1fff_b");
        pcop(SKP, 13'd0, 13'h0001, 0, 1'b0, 1'b0, "skip_wrap1");
        pcop(GTO, 13'h1FFE, 13'h1FFE, 0, 1'b0, 1'b0, "goto1ffe");
        pcop(SKP, 13'd0, 13'h0000, 0, 1'b0, 1'b0, "skip_wrap0");
        pcop(3'd5, 13'h1234, 13'h0001, 0, 1'b0, 1'b0, "op5_next");
        stk(0, 1'b0, 1'b0, "op5_stk");

        // Nine nested CALLs: ninth overwrites the oldest slot and sets ovf.
        do_reset("reset_nest");
        for (int i = 0; i < 9; i++) begin
            pcop(CLL, 13'((i + 1) * 256), 13'((i + 1) * 256), (i < 8) ? i : 8, 1'b0, 1'b0,
                 "call_nest");
            stk((i < 7) ? i + 1 : 8, i == 8, 1'b0, "call_nest_push");
        end
        for (int k = 0; k < 8; k++) begin
            pcop(RET, 13'd0, 13'((8 - k) * 256 + 1), 8 - k, 1'b1, 1'b0, "ret_nest");
            stk(7 - k, 1'b1, 1'b0, "ret_nest_pop");
        end
        pcop(RET, 13'd0, 13'h0801, 0, 1'b1, 1'b0, "ret_ninth");
        stk(0, 1'b1, 1'b1, "ret_ninth_pop");

        // Suppressed phase 7 after CALL: push discarded, pointer untouched.
        do_reset("reset_supp");
        pcop(CLL, 13'h0055, 13'h0055, 0, 1'b0, 1'b0, "call_supp");
        pcop(NXT, 13'd0, 13'h0056, 0, 1'b0, 1'b0, "next_after_supp");
        stk(0, 1'b0, 1'b0, "supp_stk");
        pcop(RET, 13'd0, 13'h0701, 0, 1'b0, 1'b0, "ret_stale7");
        stk(0, 1'b0, 1'b1, "ret_stale7_pop");

        // Reset in WAIT_STK, stray en_stack, and simultaneous strobes.
        do_reset("reset_pre");
        pcop(GTO, 13'h0200, 13'h0200, 0, 1'b0, 1'b0, "goto200");
        stk(0, 1'b0, 1'b0, "goto200_stk");
        pcop(CLL, 13'h0333, 13'h0333, 0, 1'b0, 1'b0, "call333");
        do_reset("reset_waitstk");
        stk(0, 1'b0, 1'b0, "stk_after_reset");
        pcop(RET, 13'd0, 13'h0701, 0, 1'b0, 1'b0, "ret_no_push");
        drive(1'b1, 1'b1, NXT, 13'd0);
        expect_out(13'h0702, 0, 1'b0, 1'b0, "both_strobes");
        stk(0, 1'b0, 1'b0, "both_strobes_stk");
        pcop(RET, 13'd0, 13'h0701, 0, 1'b0, 1'b0, "ret_no_pop");
        stk(0, 1'b0, 1'b1, "ret_no_pop_stk");

        repeat (4) @(negedge clock);
        #1;
        checks++;
        if (q_pc.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", q_pc.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
